mdll_lock_seq: RTL
==================

Name: mdll_lock_seq

Overview:
- Power-up and lock sequencer for the MDLL core and tracking loop.
- Runs the bring-up order: core reset, oscillator enable, external mtune preset, injection enable, then hand-off to the closed loop.
- Decides lock from the loop-filter mtune word (lf_out[12:6]) and enables dithering only while locked.
- Runs in the reference-clock domain. Its outputs replace the static register-file drives of reset, en_osc, en_ext_tune, ext_mtune, en_inj and en_dith.

Parameters:
- CNT_W, 16, width of the phase timer; must hold the largest cycle count below.
- RST_CYC, 16, cycles that core_reset is held in RST.
- OSC_CYC, 64, oscillator settle cycles in OSC; also the dwell in INJ.
- TUNE_CYC, 256, cycles of external mtune preset before injection.
- LOCK_WIN, 128, consecutive in-tolerance cycles required to declare lock.
- LOCK_TOL, 2, allowed |mtune_fb - mtune_ref| in LSBs.
- TIMEOUT_CYC, 4096, TRACK-state lock timeout; used only with the optional feature.

Ports:
- clk  in  1  reference clock
- rstb  in  1  async reset, active low
- start  in  1  single-cycle pulse; starts the sequence from IDLE
- stop  in  1  level; forces IDLE
- mtune_init  in  7  preset value for ext_mtune, latched on accepted start
- mtune_fb  in  7  live mtune (lf_out[12:6])
- cfg_dith_en  in  2  dither enable to apply while locked
- core_reset  out  1  to core reset, active high
- osc_en  out  1  to en_osc
- ext_tune_en  out  1  to en_ext_tune
- ext_mtune  out  7  to ext_mtune
- inj_en  out  1  to en_inj
- dith_en  out  2  to en_dith
- locked  out  1  lock status
- lock_lost  out  1  sticky: lock dropped since last start
- busy  out  1  state != IDLE
- seq_state  out  3  current state encoding

Behaviour:
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Reset values: state IDLE, core_reset=1, all other outputs 0, timer 0.
- State encoding: IDLE=0, RST=1, OSC=2, PRESET=3, INJ=4, TRACK=5, LOCK=6, FAIL=7.
- Output set per state:
  - IDLE: core_reset=1; osc_en, ext_tune_en, inj_en, dith_en all 0.
  - RST: core_reset=1.
  - OSC: osc_en=1.
  - PRESET: osc_en=1, ext_tune_en=1.
  - INJ: osc_en=1, ext_tune_en=1, inj_en=1.
  - TRACK: osc_en=1, inj_en=1.
  - LOCK: osc_en=1, inj_en=1, locked=1, dith_en=cfg_dith_en.
  - FAIL: same as IDLE, plus lock_lost=1.
- ext_mtune holds the latched mtune_init from an accepted start until the next accepted start.
- Transitions:
  - IDLE -> RST on start.
  - RST -> OSC after RST_CYC cycles.
  - OSC -> PRESET after OSC_CYC cycles.
  - PRESET -> INJ after TUNE_CYC cycles.
  - INJ -> TRACK after OSC_CYC cycles.
- Timer: cleared on every state change. A state of N cycles exits when timer==N-1.
- TRACK lock detection:
  - On entry: mtune_ref<=mtune_fb, window count cleared.
  - Each cycle, diff = unsigned 8-bit |mtune_fb - mtune_ref|.
  - diff>LOCK_TOL: mtune_ref<=mtune_fb, count<=0.
  - Otherwise count++; when count==LOCK_WIN-1, go to LOCK.
- LOCK: if diff>LOCK_TOL, go to TRACK and set lock_lost. locked and dith_en drop on that same edge; mtune_ref is reloaded on TRACK entry.
- stop has priority over everything: from any state, next state is IDLE. start with stop both high is ignored.
- start outside IDLE is ignored. An accepted start clears lock_lost and relatches mtune_init.
- rstb assertion mid-sequence returns immediately to reset values, asynchronously.
- mtune_fb at rail (0 or 127) is treated as a normal value; no special case.

Optional Feature:
- Macro MDLL_LOCK_TIMEOUT_EN.
- Defined: a second counter runs in TRACK only and is cleared on TRACK entry. Reaching TIMEOUT_CYC-1 goes to FAIL. FAIL holds the IDLE outputs with lock_lost=1 and leaves only on start (-> RST) or stop (-> IDLE). The counter is not cleared by in-tolerance cycles.
- Not defined: no timeout counter, TRACK waits indefinitely, FAIL is unreachable, and encoding 7 is treated as IDLE.

Test Plan:
- Nominal bring-up, defaults, start at edge 0, mtune_init=40, mtune_fb constant 52 -> states entered on these edges: RST at 1, OSC at 17, PRESET at 81, INJ at 337, TRACK at 401; locked=1 at edge 529; ext_mtune=40 throughout; dith_en=cfg_dith_en=2'b11 from 529.
- In-tolerance wander: in TRACK, mtune_fb toggles 52/54 -> no window restart, locked at 529. mtune_fb=55 at edge 450 -> window restarts with ref=55, locked at 578.
- Lock loss: in LOCK with ref=52, mtune_fb steps to 60 -> next edge locked=0, dith_en=0, lock_lost=1, state TRACK; relock after 128 stable cycles while lock_lost stays 1.
- Stop and restart: stop during PRESET -> next edge IDLE, core_reset=1, osc_en=0, ext_tune_en=0. start with stop also high -> ignored. start after stop falls -> full sequence, lock_lost cleared.
- Async reset: rstb low mid-INJ -> outputs at reset values without a clock edge; start ignored until rstb is released.
- With MDLL_LOCK_TIMEOUT_EN and TIMEOUT_CYC=300: mtune_fb changes by 5 every 10 cycles -> FAIL 300 cycles after TRACK entry, seq_state=7, lock_lost=1; a new start -> RST.

Source files
------------

// File: rtl/mdll_lock_seq_if.sv
// Handshake bundle between the MDLL lock sequencer and its controller / MDLL core.
// The controller side (master) drives the sequence controls and the live mtune word.
// The sequencer side (slave) drives the core enables and the status outputs.
interface mdll_lock_seq_if;
    logic       start;
    logic       stop;
    logic [6:0] mtune_init;
    logic [6:0] mtune_fb;
    logic [1:0] cfg_dith_en;
    logic       core_reset;
    logic       osc_en;
    logic       ext_tune_en;
    logic [6:0] ext_mtune;
    logic       inj_en;
    logic [1:0] dith_en;
    logic       locked;
    logic       lock_lost;
    logic       busy;
    logic [2:0] seq_state;

    modport master (
        output start, stop, mtune_init, mtune_fb, cfg_dith_en,
        input  core_reset, osc_en, ext_tune_en, ext_mtune, inj_en, dith_en,
        input  locked, lock_lost, busy, seq_state
    );

    modport slave (
        input  start, stop, mtune_init, mtune_fb, cfg_dith_en,
        output core_reset, osc_en, ext_tune_en, ext_mtune, inj_en, dith_en,
        output locked, lock_lost, busy, seq_state
    );
endinterface

// File: rtl/mdll_lock_seq.sv
// MDLL power-up and lock sequencer (reference-clock domain).
// Walks core reset -> oscillator enable -> external mtune preset -> injection -> closed-loop
// tracking, declares lock from the loop-filter mtune word and enables dither only while locked.
// Optional macro MDLL_LOCK_TIMEOUT_EN adds a TRACK timeout that parks the sequence in FAIL.
module mdll_lock_seq #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned RST_CYC     = 16,
    parameter int unsigned OSC_CYC     = 64,
    parameter int unsigned TUNE_CYC    = 256,
    parameter int unsigned LOCK_WIN    = 128,
    parameter int unsigned LOCK_TOL    = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic            clk,
    input  logic            rstb,
    mdll_lock_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRst    = 3'd1,
        StOsc    = 3'd2,
        StPreset = 3'd3,
        StInj    = 3'd4,
        StTrack  = 3'd5,
        StLock   = 3'd6,
        StFail   = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [6:0]       ref_q, ref_d;
    logic [6:0]       ext_mtune_q, ext_mtune_d;
    logic             lock_lost_q, lock_lost_d;
    logic             core_reset_q, core_reset_d;
    logic             osc_en_q, osc_en_d;
    logic             ext_tune_en_q, ext_tune_en_d;
    logic             inj_en_q, inj_en_d;
    logic [1:0]       dith_en_q, dith_en_d;
    logic             locked_q, locked_d;
    logic             busy_q, busy_d;
    logic [7:0]       diff;
    logic             in_tol;
    logic             start_ok;
`ifdef MDLL_LOCK_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_q, tmo_d;
`endif

    // State, timers and registered outputs; rstb clears everything asynchronously.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            win_q         <= '0;
            ref_q         <= '0;
            ext_mtune_q   <= '0;
            lock_lost_q   <= 1'b0;
            core_reset_q  <= 1'b1;
            osc_en_q      <= 1'b0;
            ext_tune_en_q <= 1'b0;
            inj_en_q      <= 1'b0;
            dith_en_q     <= 2'b00;
            locked_q      <= 1'b0;
            busy_q        <= 1'b0;
`ifdef MDLL_LOCK_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            win_q         <= win_d;
            ref_q         <= ref_d;
            ext_mtune_q   <= ext_mtune_d;
            lock_lost_q   <= lock_lost_d;
            core_reset_q  <= core_reset_d;
            osc_en_q      <= osc_en_d;
            ext_tune_en_q <= ext_tune_en_d;
            inj_en_q      <= inj_en_d;
            dith_en_q     <= dith_en_d;
            locked_q      <= locked_d;
            busy_q        <= busy_d;
`ifdef MDLL_LOCK_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    // Next state, lock window bookkeeping, and outputs decoded from the next state.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        win_d       = win_q;
        ref_d       = ref_q;
        ext_mtune_d = ext_mtune_q;
        lock_lost_d = lock_lost_q;
        start_ok    = 1'b0;
`ifdef MDLL_LOCK_TIMEOUT_EN
        tmo_d       = (state_q == StTrack) ? tmo_q + 1'b1 : tmo_q;
`endif
        // Rail values of mtune_fb need no special case: the 8-bit difference cannot wrap.
        diff   = ({1'b0, bus.mtune_fb} >= {1'b0, ref_q}) ?
                 ({1'b0, bus.mtune_fb} - {1'b0, ref_q}) :
                 ({1'b0, ref_q} - {1'b0, bus.mtune_fb});
        in_tol = (diff <= 8'(LOCK_TOL));

        if (bus.stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StRst:    if (timer_q == CNT_W'(RST_CYC - 1))  state_d = StOsc;
                StOsc:    if (timer_q == CNT_W'(OSC_CYC - 1))  state_d = StPreset;
                StPreset: if (timer_q == CNT_W'(TUNE_CYC - 1)) state_d = StInj;
                StInj:    if (timer_q == CNT_W'(OSC_CYC - 1))  state_d = StTrack;
                StTrack: begin
`ifdef MDLL_LOCK_TIMEOUT_EN
                    // The timeout runs on total TRACK time, not on the in-tolerance window.
                    if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_d     = StFail;
                        lock_lost_d = 1'b1;
                    end else
`endif
                    if (!in_tol) begin
                        ref_d = bus.mtune_fb;
                        win_d = '0;
                    end else if (win_q == CNT_W'(LOCK_WIN - 1)) begin
                        state_d = StLock;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
                StLock: begin
                    if (!in_tol) begin
                        state_d     = StTrack;
                        lock_lost_d = 1'b1;
                    end
                end
                // IDLE, FAIL, and encoding 7 when the timeout is compiled out.
                default: begin
                    if (bus.start) begin
                        state_d  = StRst;
                        start_ok = 1'b1;
                    end
                end
            endcase
        end

        if (start_ok) begin
            ext_mtune_d = bus.mtune_init;
            lock_lost_d = 1'b0;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end

        // Fresh reference and window whenever TRACK is (re)entered, including from LOCK.
        if ((state_d == StTrack) && (state_q != StTrack)) begin
            ref_d = bus.mtune_fb;
            win_d = '0;
`ifdef MDLL_LOCK_TIMEOUT_EN
            tmo_d = '0;
`endif
        end

        core_reset_d  = state_d inside {StIdle, StRst, StFail};
        osc_en_d      = state_d inside {StOsc, StPreset, StInj, StTrack, StLock};
        ext_tune_en_d = state_d inside {StPreset, StInj};
        inj_en_d      = state_d inside {StInj, StTrack, StLock};
        locked_d      = (state_d == StLock);
        dith_en_d     = (state_d == StLock) ? bus.cfg_dith_en : 2'b00;
        busy_d        = (state_d != StIdle);
    end

    assign bus.core_reset  = core_reset_q;
    assign bus.osc_en      = osc_en_q;
    assign bus.ext_tune_en = ext_tune_en_q;
    assign bus.ext_mtune   = ext_mtune_q;
    assign bus.inj_en      = inj_en_q;
    assign bus.dith_en     = dith_en_q;
    assign bus.locked      = locked_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.busy        = busy_q;
    assign bus.seq_state   = state_q;

endmodule
